// File: rtl/axil_pkg.sv
// Shared types and helpers for the AXI4-Lite register front-end.
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        W_IDLE,
        W_HAVE_A,
        W_HAVE_D,
        W_EXEC,
        W_RESP
    } wr_state_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_EXEC,
        R_RESP
    } rd_state_e;

    typedef struct packed {
        logic        in_range;
        logic [31:0] idx;
    } dec_t;

    // Word index and range check; byte-offset bits below addr_lsb are ignored.
    function automatic dec_t addr_decode(input logic [63:0] addr,
                                         input int unsigned addr_lsb,
                                         input int unsigned num_regs);
        dec_t d;
        d.in_range = (addr >> addr_lsb) < 64'(num_regs);
        d.idx      = 32'(addr >> addr_lsb);
        return d;
    endfunction

endpackage

// File: rtl/axil_regif_gen.sv
// AXI4-Lite slave mapping NUM_REGS word registers onto a generic register port.
// Write and read channels run independent FSMs, one outstanding transfer each.
module axil_regif_gen
    import axil_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = 4,
    parameter logic [NUM_REGS-1:0] RO_MASK = NUM_REGS'(32'b0010),
    parameter logic [NUM_REGS-1:0] WO_MASK = NUM_REGS'(32'b0001),
    localparam int unsigned STRB_W  = DATA_W / 8,
    localparam int unsigned IDX_W   = $clog2(NUM_REGS)
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    input  logic [ADDR_W-1:0] s_axi_awaddr,
    input  logic [2:0]        s_axi_awprot,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    input  logic [DATA_W-1:0] s_axi_wdata,
    input  logic [STRB_W-1:0] s_axi_wstrb,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,
    output logic [1:0]        s_axi_bresp,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    input  logic [ADDR_W-1:0] s_axi_araddr,
    input  logic [2:0]        s_axi_arprot,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready,
    output logic [DATA_W-1:0] s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              reg_wr_en,
    output logic [IDX_W-1:0]  reg_wr_idx,
    output logic [DATA_W-1:0] reg_wr_data,
    output logic [STRB_W-1:0] reg_wr_strb,
    input  logic              reg_wr_err,
    output logic              reg_rd_en,
    output logic [IDX_W-1:0]  reg_rd_idx,
    input  logic [DATA_W-1:0] reg_rd_data,
    input  logic              reg_rd_err
);

    localparam int unsigned ADDR_LSB = $clog2(STRB_W);

    wr_state_e        wr_state_q;
    rd_state_e        rd_state_q;
    logic             wr_ok_q;     // latched address is in range and writable
    dec_t             aw_dec, ar_dec;
    logic [IDX_W-1:0] aw_idx, ar_idx;
    logic             aw_ok, ar_ok;
    logic             aw_hs, w_hs, ar_hs;
    logic             unused_bits;

    // Protection bits are ignored; upper decode bits are folded into the range check.
    assign unused_bits = ^{s_axi_awprot, s_axi_arprot, aw_dec.idx, ar_dec.idx};

    // Address decode and channel handshakes
    always_comb begin
        aw_dec = addr_decode(64'(s_axi_awaddr), ADDR_LSB, NUM_REGS);
        ar_dec = addr_decode(64'(s_axi_araddr), ADDR_LSB, NUM_REGS);
        aw_idx = aw_dec.idx[IDX_W-1:0];
        ar_idx = ar_dec.idx[IDX_W-1:0];
        aw_ok  = aw_dec.in_range && !RO_MASK[aw_idx];
        ar_ok  = ar_dec.in_range && !WO_MASK[ar_idx];
        aw_hs  = s_axi_awvalid && s_axi_awready;
        w_hs   = s_axi_wvalid && s_axi_wready;
        ar_hs  = s_axi_arvalid && s_axi_arready;
    end

    // Write channel FSM; readies are registered so they stay low one cycle after reset
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_state_q    <= W_IDLE;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= RESP_OKAY;
            reg_wr_en     <= 1'b0;
            reg_wr_idx    <= '0;
            reg_wr_data   <= '0;
            reg_wr_strb   <= '0;
            wr_ok_q       <= 1'b0;
        end else begin
            case (wr_state_q)
                W_IDLE: begin
                    if (aw_hs && w_hs) begin
                        reg_wr_idx    <= aw_idx;
                        wr_ok_q       <= aw_ok;
                        reg_wr_data   <= s_axi_wdata;
                        reg_wr_strb   <= s_axi_wstrb;
                        reg_wr_en     <= aw_ok && (|s_axi_wstrb);
                        s_axi_awready <= 1'b0;
                        s_axi_wready  <= 1'b0;
                        wr_state_q    <= W_EXEC;
                    end else if (aw_hs) begin
                        reg_wr_idx    <= aw_idx;
                        wr_ok_q       <= aw_ok;
                        s_axi_awready <= 1'b0;
                        wr_state_q    <= W_HAVE_A;
                    end else if (w_hs) begin
                        reg_wr_data   <= s_axi_wdata;
                        reg_wr_strb   <= s_axi_wstrb;
                        s_axi_wready  <= 1'b0;
                        wr_state_q    <= W_HAVE_D;
                    end else begin
                        s_axi_awready <= 1'b1;
                        s_axi_wready  <= 1'b1;
                    end
                end
                W_HAVE_A: begin
                    if (w_hs) begin
                        reg_wr_data  <= s_axi_wdata;
                        reg_wr_strb  <= s_axi_wstrb;
                        reg_wr_en    <= wr_ok_q && (|s_axi_wstrb);
                        s_axi_wready <= 1'b0;
                        wr_state_q   <= W_EXEC;
                    end
                end
                W_HAVE_D: begin
                    if (aw_hs) begin
                        reg_wr_idx    <= aw_idx;
                        wr_ok_q       <= aw_ok;
                        reg_wr_en     <= aw_ok && (|reg_wr_strb);
                        s_axi_awready <= 1'b0;
                        wr_state_q    <= W_EXEC;
                    end
                end
                W_EXEC: begin
                    reg_wr_en    <= 1'b0;
                    s_axi_bvalid <= 1'b1;
                    s_axi_bresp  <= (!wr_ok_q || (reg_wr_en && reg_wr_err)) ? RESP_SLVERR
                                                                            : RESP_OKAY;
                    wr_state_q   <= W_RESP;
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        s_axi_bvalid  <= 1'b0;
                        s_axi_awready <= 1'b1;
                        s_axi_wready  <= 1'b1;
                        wr_state_q    <= W_IDLE;
                    end
                end
                default: wr_state_q <= W_IDLE;
            endcase
        end
    end

    // Read channel FSM; read data is captured in the single strobe cycle
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_state_q    <= R_IDLE;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rdata   <= '0;
            s_axi_rresp   <= RESP_OKAY;
            reg_rd_en     <= 1'b0;
            reg_rd_idx    <= '0;
        end else begin
            case (rd_state_q)
                R_IDLE: begin
                    if (ar_hs) begin
                        reg_rd_idx    <= ar_idx;
                        reg_rd_en     <= ar_ok;
                        s_axi_arready <= 1'b0;
                        rd_state_q    <= R_EXEC;
                    end else begin
                        s_axi_arready <= 1'b1;
                    end
                end
                R_EXEC: begin
                    reg_rd_en    <= 1'b0;
                    s_axi_rvalid <= 1'b1;
                    // reg_rd_en doubles as "address legal" in this cycle
                    if (reg_rd_en && !reg_rd_err) begin
                        s_axi_rdata <= reg_rd_data;
                        s_axi_rresp <= RESP_OKAY;
                    end else begin
                        s_axi_rdata <= '0;
                        s_axi_rresp <= RESP_SLVERR;
                    end
                    rd_state_q <= R_RESP;
                end
                R_RESP: begin
                    if (s_axi_rready) begin
                        s_axi_rvalid  <= 1'b0;
                        s_axi_arready <= 1'b1;
                        rd_state_q    <= R_IDLE;
                    end
                end
                default: rd_state_q <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axil_regif_gen.sv
// Directed bench for axil_regif_gen with scoreboard queues for strobes and responses.
module tb_axil_regif_gen;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        s_axi_awvalid = 1'b0, s_axi_awready;
    logic [31:0] s_axi_awaddr = '0;
    logic [2:0]  s_axi_awprot = '0;
    logic        s_axi_wvalid = 1'b0, s_axi_wready;
    logic [31:0] s_axi_wdata = '0;
    logic [3:0]  s_axi_wstrb = '0;
    logic        s_axi_bvalid, s_axi_bready = 1'b0;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_arvalid = 1'b0, s_axi_arready;
    logic [31:0] s_axi_araddr = '0;
    logic [2:0]  s_axi_arprot = '0;
    logic        s_axi_rvalid, s_axi_rready = 1'b0;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        reg_wr_en;
    logic [1:0]  reg_wr_idx;
    logic [31:0] reg_wr_data;
    logic [3:0]  reg_wr_strb;
    logic        reg_wr_err = 1'b0;
    logic        reg_rd_en;
    logic [1:0]  reg_rd_idx;
    logic [31:0] reg_rd_data = '0;
    logic        reg_rd_err = 1'b0;

    localparam logic [1:0] OKAY = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    int checks = 0;
    int errors = 0;

    logic [37:0] wr_q[$];   // {idx, strb, data}
    logic [1:0]  rd_q[$];   // idx
    logic [1:0]  b_q[$];    // bresp
    logic [33:0] r_q[$];    // {rresp, rdata}

    axil_regif_gen dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awprot  (s_axi_awprot),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arprot  (s_axi_arprot),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .reg_wr_en     (reg_wr_en),
        .reg_wr_idx    (reg_wr_idx),
        .reg_wr_data   (reg_wr_data),
        .reg_wr_strb   (reg_wr_strb),
        .reg_wr_err    (reg_wr_err),
        .reg_rd_en     (reg_rd_en),
        .reg_rd_idx    (reg_rd_idx),
        .reg_rd_data   (reg_rd_data),
        .reg_rd_err    (reg_rd_err)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_avail(input string tag, input int n);
        checks++;
        assert (n > 0) else begin
            errors++;
            $error("FAIL %s: observed unexpected DUT output, expected none", tag);
        end
    endtask

    // Scoreboard: pop and compare whenever the DUT produces a strobe or response
    always @(negedge aclk) begin
        if (reg_wr_en) begin
            chk_avail("wr_strobe_unexpected", wr_q.size());
            if (wr_q.size() > 0) chk("wr_strobe", {reg_wr_idx, reg_wr_strb, reg_wr_data},
                                     wr_q.pop_front());
        end
        if (reg_rd_en) begin
            chk_avail("rd_strobe_unexpected", rd_q.size());
            if (rd_q.size() > 0) chk("rd_strobe", reg_rd_idx, rd_q.pop_front());
        end
        if (s_axi_bvalid && s_axi_bready) begin
            chk_avail("b_unexpected", b_q.size());
            if (b_q.size() > 0) chk("bresp", s_axi_bresp, b_q.pop_front());
        end
        if (s_axi_rvalid && s_axi_rready) begin
            chk_avail("r_unexpected", r_q.size());
            if (r_q.size() > 0) chk("rresp_rdata", {s_axi_rresp, s_axi_rdata}, r_q.pop_front());
        end
    end

    task automatic send_aw(input logic [31:0] addr);
        bit ok = 0;
        s_axi_awaddr = addr;
        s_axi_awvalid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge aclk);
            if (s_axi_awready) begin ok = 1; break; end
        end
        chk("aw_handshake", ok, 1);
        @(posedge aclk); #1;
        s_axi_awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] data, input logic [3:0] strb);
        bit ok = 0;
        s_axi_wdata = data;
        s_axi_wstrb = strb;
        s_axi_wvalid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge aclk);
            if (s_axi_wready) begin ok = 1; break; end
        end
        chk("w_handshake", ok, 1);
        @(posedge aclk); #1;
        s_axi_wvalid = 1'b0;
    endtask

    task automatic send_ar(input logic [31:0] addr);
        bit ok = 0;
        s_axi_araddr = addr;
        s_axi_arvalid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge aclk);
            if (s_axi_arready) begin ok = 1; break; end
        end
        chk("ar_handshake", ok, 1);
        @(posedge aclk); #1;
        s_axi_arvalid = 1'b0;
    endtask

    task automatic wait_b();
        bit ok = 0;
        s_axi_bready = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge aclk);
            if (s_axi_bvalid) begin ok = 1; break; end
        end
        chk("b_timeout", ok, 1);
        @(posedge aclk); #1;
        s_axi_bready = 1'b0;
    endtask

    // mode 0: AW and W together; 1: W first, AW gap cycles later; 2: AW first
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int mode, input int gap,
                             input bit exp_strobe, input logic [1:0] exp_resp);
        logic [1:0] idx;
        idx = 2'(addr >> 2);
        if (exp_strobe) wr_q.push_back({idx, strb, data});
        b_q.push_back(exp_resp);
        if (mode == 0) begin
            fork
                send_aw(addr);
                send_w(data, strb);
            join
        end else if (mode == 1) begin
            send_w(data, strb);
            repeat (gap) @(posedge aclk);
            #1;
            send_aw(addr);
        end else begin
            send_aw(addr);
            repeat (gap) @(posedge aclk);
            #1;
            send_w(data, strb);
        end
        wait_b();
    endtask

    task automatic axi_read(input logic [31:0] addr, input bit exp_strobe,
                            input logic [31:0] exp_data, input logic [1:0] exp_resp,
                            input int hold);
        bit ok = 0;
        logic [1:0] idx;
        idx = 2'(addr >> 2);
        if (exp_strobe) rd_q.push_back(idx);
        r_q.push_back({exp_resp, exp_data});
        send_ar(addr);
        s_axi_rready = (hold == 0);
        for (int n = 0; n < 50; n++) begin
            @(negedge aclk);
            if (s_axi_rvalid) begin ok = 1; break; end
        end
        chk("r_timeout", ok, 1);
        for (int i = 0; i < hold; i++) begin
            chk("r_hold_valid", s_axi_rvalid, 1);
            chk("r_hold_data", {s_axi_rresp, s_axi_rdata}, {exp_resp, exp_data});
            @(negedge aclk);
        end
        if (hold > 0) begin
            @(posedge aclk); #1;
            s_axi_rready = 1'b1;
            @(negedge aclk);
        end
        @(posedge aclk); #1;
        s_axi_rready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        // Reset state
        #12;
        chk("rst_ctrl", {s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp, s_axi_arready,
                         s_axi_rvalid, s_axi_rresp, reg_wr_en, reg_wr_idx, reg_wr_strb,
                         reg_rd_en, reg_rd_idx}, '0);
        chk("rst_data", {s_axi_rdata, reg_wr_data}, '0);
        @(negedge aclk);
        aresetn = 1'b1;
        repeat (2) @(posedge aclk);
        #1;

        // 1. Simultaneous AW/W with latency check
        wr_q.push_back({2'd0, 4'hF, 32'h0000_00A5});
        b_q.push_back(OKAY);
        fork
            send_aw(32'h0);
            send_w(32'h0000_00A5, 4'hF);
        join
        @(negedge aclk);
        chk("t1_wr_en_T+1", reg_wr_en, 1);
        @(negedge aclk);
        chk("t1_bvalid_T+2", {s_axi_bvalid, reg_wr_en}, 2'b10);
        @(posedge aclk); #1;
        wait_b();

        // 2. W before AW, then AW before W
        axi_write(32'h8, 32'h11, 4'hF, 1, 3, 1, OKAY);
        axi_write(32'h8, 32'h22, 4'h3, 2, 3, 1, OKAY);

        // 3. Illegal accesses
        reg_rd_data = 32'h1234_5678;
        axi_write(32'h4, 32'h33, 4'hF, 0, 0, 0, SLVERR);
        axi_write(32'h10, 32'h44, 4'hF, 0, 0, 0, SLVERR);
        axi_read(32'h0, 0, 32'h0, SLVERR, 0);
        // Zero strobe on a legal register: OKAY, no strobe
        axi_write(32'hC, 32'h55, 4'h0, 0, 0, 0, OKAY);
        // Low address bits ignored
        axi_read(32'hB, 1, 32'h1234_5678, OKAY, 0);

        // 4. Held read response
        reg_rd_data = 32'hDEAD_BEEF;
        axi_read(32'hC, 1, 32'hDEAD_BEEF, OKAY, 5);

        // 5. Peripheral-side errors
        reg_wr_err = 1'b1;
        axi_write(32'h8, 32'h66, 4'hF, 0, 0, 1, SLVERR);
        reg_wr_err = 1'b0;
        reg_rd_err = 1'b1;
        axi_read(32'hC, 1, 32'h0, SLVERR, 0);
        reg_rd_err = 1'b0;

        // 6. Reset with write in W_RESP and read in R_EXEC
        wr_q.push_back({2'd2, 4'hF, 32'h0000_0077});
        fork
            send_aw(32'h8);
            send_w(32'h77, 4'hF);
        join
        send_ar(32'hC);
        aresetn = 1'b0;
        #1;
        chk("t6_rst_outputs", {s_axi_bvalid, s_axi_rvalid, reg_wr_en, reg_rd_en,
                               s_axi_awready, s_axi_wready, s_axi_arready}, '0);
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        #1;
        chk("t6_ready_after_release", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b000);
        @(posedge aclk); #1;
        chk("t6_ready_next_cycle", {s_axi_awready, s_axi_wready, s_axi_arready,
                                    s_axi_bvalid, s_axi_rvalid}, 5'b11100);
        axi_write(32'h8, 32'h88, 4'hF, 0, 0, 1, OKAY);
        axi_read(32'h8, 1, 32'hDEAD_BEEF, OKAY, 0);

        repeat (3) @(posedge aclk);
        #1;
        chk("wr_q_drained", wr_q.size(), 0);
        chk("rd_q_drained", rd_q.size(), 0);
        chk("b_q_drained", b_q.size(), 0);
        chk("r_q_drained", r_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
